// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one operation at a time behind START/READY and RESULT_VALID/RESULT_READY.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             READY,
  input  logic [4:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             KILL,
  output logic [WIDTH-1:0] RESULT,
  output logic             RESULT_VALID,
  input  logic             RESULT_READY,
  output logic             BUSY
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             neg_a_reg, neg_a_next;
  logic             neg_b_reg, neg_b_next;
  logic             special_reg, special_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] result_reg, result_next;

  logic [2:0] func3;
  logic       is_m, is_div, signed_a, signed_b;

  assign func3    = op_reg[4:2];
  assign is_m     = (op_reg[1:0] == 2'b01);
  assign is_div   = func3[2];
  assign signed_a = (func3 == 3'b001) || (func3 == 3'b010) ||
                    (func3 == 3'b100) || (func3 == 3'b110);
  assign signed_b = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = signed_a & a_reg[WIDTH-1];
  assign sign_b = signed_b & b_reg[WIDTH-1];
  assign mag_a  = sign_a ? -a_reg : a_reg;
  assign mag_b  = sign_b ? -b_reg : b_reg;

  // Multiply: {hi,lo} shifts right; lo starts as the multiplier and fills with product bits.
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_sum;

  assign addend  = lo_reg[0] ? mcand_reg : '0;
  assign add_sum = {1'b0, hi_reg} + {1'b0, addend};

  // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign shifted = {hi_reg, lo_reg[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, mcand_reg});
  assign diff    = shifted[WIDTH-1:0] - mcand_reg;

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_word;

  assign prod     = {hi_reg, lo_reg};
  assign prod_fix = (neg_a_reg ^ neg_b_reg) ? -prod : prod;
  assign quo_fix  = (neg_a_reg ^ neg_b_reg) ? -lo_reg : lo_reg;
  assign rem_fix  = neg_a_reg ? -hi_reg : hi_reg;

  always_comb begin
    final_word = '0;
    if (special_reg)
      final_word = hi_reg;
    else if (is_div)
      final_word = func3[1] ? rem_fix : quo_fix;
    else if (func3 == 3'b000)
      final_word = prod_fix[WIDTH-1:0];
    else
      final_word = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    neg_a_next   = neg_a_reg;
    neg_b_next   = neg_b_reg;
    special_next = special_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    mcand_next   = mcand_reg;
    count_next   = count_reg;
    result_next  = result_reg;

    if (KILL && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (START && !KILL) begin
            op_next    = SELECT;
            a_next     = DATA1;
            b_next     = DATA2;
            state_next = S_PREP;
          end
        end
        S_PREP: begin
          neg_a_next   = sign_a;
          neg_b_next   = sign_b;
          hi_next      = '0;
          count_next   = '0;
          lo_next      = is_div ? mag_a : mag_b;
          mcand_next   = is_div ? mag_b : mag_a;
          special_next = 1'b1;
          state_next   = S_FIX;
          // Special results are parked in hi so FIX can pick them up unchanged.
          if (!is_m)
            hi_next = '0;
          else if (is_div && (b_reg == '0))
            hi_next = func3[1] ? a_reg : '1;
          else if (is_div && !func3[0] && (a_reg == MOST_NEG) && (b_reg == '1))
            hi_next = func3[1] ? '0 : a_reg;
          else begin
            special_next = 1'b0;
            state_next   = S_CALC;
          end
        end
        S_CALC: begin
          if (is_div) begin
            hi_next = fits ? diff : shifted[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], fits};
          end else begin
            hi_next = add_sum[WIDTH:1];
            lo_next = {add_sum[0], lo_reg[WIDTH-1:1]};
          end
          count_next = count_reg + 1'b1;
          if (count_reg == LAST)
            state_next = S_FIX;
        end
        S_FIX: begin
          result_next = final_word;
          state_next  = S_DONE;
        end
        S_DONE: begin
          if (RESULT_READY)
            state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
      special_reg <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      mcand_reg   <= '0;
      count_reg   <= '0;
      result_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      neg_a_reg   <= neg_a_next;
      neg_b_reg   <= neg_b_next;
      special_reg <= special_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      mcand_reg   <= mcand_next;
      count_reg   <= count_next;
      result_reg  <= result_next;
    end
  end

  assign READY        = (state_reg == S_IDLE);
  assign BUSY         = ~READY;
  assign RESULT_VALID = (state_reg == S_DONE);
  assign RESULT       = result_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases, handshake/abort corners
// and randomized operations against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [4:0] OP_MUL    = 5'b00001;
  localparam logic [4:0] OP_MULH   = 5'b00101;
  localparam logic [4:0] OP_MULHSU = 5'b01001;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b10001;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b11001;
  localparam logic [4:0] OP_REMU   = 5'b11101;
  localparam logic [4:0] OP_BAD    = 5'b00010;

  logic         CLK = 1'b0;
  logic         RESET, START, READY, KILL, RESULT_VALID, RESULT_READY, BUSY;
  logic [4:0]   SELECT;
  logic [W-1:0] DATA1, DATA2, RESULT;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_result;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .READY(READY), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics in plain 64-bit / int arithmetic.
  function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    model = '0;
    case (sel)
      OP_MUL:    begin p = ua * ub; model = p[31:0];  end
      OP_MULH:   begin p = sa * sb; model = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; model = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; model = p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
        else model = 32'(ia / ib);
      end
      OP_DIVU: model = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'd0;
        else model = 32'(ia % ib);
      end
      OP_REMU: model = (b == 32'd0) ? a : a % b;
      default: model = '0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] sel, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!(sel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU}))
      return 3;
    if ((sel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && b == 32'd0)
      return 3;
    if ((sel inside {OP_DIV, OP_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 3;
    return W + 3;
  endfunction

  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge CLK);
    while (!READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check1("ready_before_issue", READY, 1'b1);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
  endtask

  // Returns at the negedge of the first cycle with RESULT_VALID (or the timeout).
  task automatic await_result(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int c;
    c = 1;
    @(negedge CLK);
    while (!RESULT_VALID && c < 80) begin
      @(negedge CLK);
      c++;
    end
    check32({tag, "_latency"}, c, exp_lat);
    check32({tag, "_result"}, RESULT, exp_res);
    check1({tag, "_busy"}, BUSY, 1'b1);
    check1({tag, "_ready_low"}, READY, 1'b0);
  endtask

  task automatic accept_result(input string tag);
    RESULT_READY = 1'b1;
    @(posedge CLK); #1;
    RESULT_READY = 1'b0;
    check1({tag, "_ready_after"}, READY, 1'b1);
    check1({tag, "_valid_after"}, RESULT_VALID, 1'b0);
    check32({tag, "_result_kept"}, RESULT, last_result);
  endtask

  task automatic run_exp(input string tag, input logic [4:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(sel, a, b);
    await_result(tag, exp, lat);
    last_result = exp;
    accept_result(tag);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  ops[9];
    logic [4:0]  sel;
    logic [31:0] a, b, exp;
    int          seen;

    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_BAD};
    RESET = 1'b1; START = 1'b0; KILL = 1'b0; RESULT_READY = 1'b0;
    SELECT = '0; DATA1 = '0; DATA2 = '0;
    last_result = '0;
    repeat (3) @(posedge CLK);
    #1;
    check32("reset_result", RESULT, 32'd0);
    check1("reset_valid", RESULT_VALID, 1'b0);
    check1("reset_busy", BUSY, 1'b0);
    check1("reset_ready", READY, 1'b1);
    RESET = 1'b0;

    run_exp("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    run_exp("mulh_7_m3", OP_MULH, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 35);
    run_exp("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    run_exp("mulhsu_ff", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    run_exp("mul_ff", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35);
    run_exp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run_exp("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run_exp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 35);
    run_exp("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 35);
    run_exp("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 3);
    run_exp("remu_by_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 3);
    run_exp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3);
    run_exp("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 3);
    run_exp("bad_select", OP_BAD, 32'd9, 32'd9, 32'd0, 3);

    // Backpressure: result held, READY low, START pulses ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    await_result("bp", 32'd14, 35);
    last_result = 32'd14;
    for (int i = 0; i < 10; i++) begin
      START = i[0]; SELECT = OP_MUL; DATA1 = $urandom; DATA2 = $urandom;
      @(posedge CLK); #1;
      check32("bp_hold_result", RESULT, 32'd14);
      check1("bp_ready_low", READY, 1'b0);
      check1("bp_valid_high", RESULT_VALID, 1'b1);
      @(negedge CLK);
    end
    START = 1'b0;
    accept_result("bp");
    run_exp("bp_next_divu", OP_DIVU, 32'd9, 32'd3, 32'd3, 35);

    // KILL in IDLE blocks acceptance.
    @(negedge CLK);
    START = 1'b1; KILL = 1'b1; SELECT = OP_MUL; DATA1 = 32'd2; DATA2 = 32'd3;
    @(posedge CLK); #1;
    START = 1'b0; KILL = 1'b0;
    check1("kill_idle_ready", READY, 1'b1);
    check1("kill_idle_busy", BUSY, 1'b0);

    // KILL during CALC (counter 12).
    issue(OP_DIV, $urandom, 32'd3);
    for (int c = 1; c <= 14; c++) begin
      @(negedge CLK);
      check1("kill_no_valid", RESULT_VALID, 1'b0);
    end
    KILL = 1'b1;
    @(posedge CLK); #1;
    KILL = 1'b0;
    check1("kill_ready", READY, 1'b1);
    check1("kill_busy", BUSY, 1'b0);
    check1("kill_valid", RESULT_VALID, 1'b0);
    check32("kill_result_kept", RESULT, last_result);
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (RESULT_VALID) seen++;
    end
    check32("kill_quiet", seen, 0);
    run_exp("kill_then_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 35);

    // KILL in DONE acts as the result handshake.
    issue(OP_DIVU, 32'd50, 32'd5);
    await_result("kill_done", 32'd10, 35);
    KILL = 1'b1;
    @(posedge CLK); #1;
    KILL = 1'b0;
    check1("kill_done_ready", READY, 1'b1);
    check1("kill_done_valid", RESULT_VALID, 1'b0);
    check32("kill_done_result", RESULT, 32'd10);
    last_result = 32'd10;

    // RESET during CALC.
    issue(OP_MULHU, $urandom, $urandom);
    for (int c = 1; c <= 14; c++) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check32("rst_mid_result", RESULT, 32'd0);
    check1("rst_mid_valid", RESULT_VALID, 1'b0);
    check1("rst_mid_busy", BUSY, 1'b0);
    check1("rst_mid_ready", READY, 1'b1);
    last_result = 32'd0;
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (RESULT_VALID) seen++;
    end
    check32("rst_quiet", seen, 0);
    run_exp("rst_then_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 35);

    // Randomized operations against the reference model, with random consumer delay.
    for (int n = 0; n < 30; n++) begin
      sel = ops[$urandom_range(0, 8)];
      a = pick();
      b = pick();
      exp = model(sel, a, b);
      issue(sel, a, b);
      await_result($sformatf("rand%0d_sel%b", n, sel), exp, latency(sel, a, b));
      last_result = exp;
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      accept_result($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M unit for the execute stage; the alternative to the single-cycle combinational multiply/divide path when timing closure needs it.
- Accepts one operation through a START/READY handshake and runs radix-2 iterative shift-add multiply or restoring divide.
- Presents the result through a RESULT_VALID/RESULT_READY handshake.
- The pipeline stalls on BUSY; KILL aborts the operation on a flush.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  request to begin an operation
READY  out  1  high only in IDLE; an operation is accepted when START&&READY at a rising edge
SELECT  in  5  {func3, func7[5], func7[0]}: MUL=00001, MULH=00101, MULHSU=01001, MULHU=01101, DIV=10001, DIVU=10101, REM=11001, REMU=11101
DATA1  in  WIDTH  rs1 operand, latched at acceptance
DATA2  in  WIDTH  rs2 operand, latched at acceptance
KILL  in  1  abort the current operation (pipeline flush)
RESULT  out  WIDTH  registered result, stable while RESULT_VALID
RESULT_VALID  out  1  result available
RESULT_READY  in  1  consumer takes the result
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - RESULT=0, RESULT_VALID=0, BUSY=0, READY=1.
  - Iteration counter and internal registers cleared.
  - Reset asserted in any state discards the operation; no RESULT_VALID follows.
- IDLE:
  - On START&&READY, latch SELECT, DATA1 and DATA2, then go to PREP.
  - START while not in IDLE is ignored; the requester must hold START until accepted.
- PREP (1 cycle):
  - Record operand signs: DATA1 signed for MULH, MULHSU, DIV, REM; DATA2 signed for MULH, DIV, REM.
  - Load magnitudes and clear the accumulator.
  - Detect special cases:
    - Divisor zero: DIV/DIVU result is all ones; REM/REMU result is the dividend.
    - Signed overflow (DIV/REM with DATA1=most negative, DATA2=all ones): DIV result is DATA1; REM result is 0.
    - Non-M SELECT code: result 0.
  - Special case goes to FIX; otherwise go to CALC.
- CALC (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: one shift-add step per cycle into a 2*WIDTH unsigned product.
  - Divide: one restoring step per cycle producing the unsigned quotient and remainder.
  - After the final step, go to FIX.
- FIX (1 cycle):
  - Apply sign correction. The product is negated if the operand signs differ.
  - The quotient is negated if the signs differ; the remainder takes the dividend's sign, so results truncate toward zero.
  - Select the output word: MUL takes the low half; MULH, MULHSU and MULHU take the high half.
  - Register RESULT and go to DONE.
- DONE:
  - RESULT_VALID=1 with RESULT held stable.
  - On RESULT_READY, go to IDLE, with RESULT_VALID=0 and READY=1 the next cycle.
  - RESULT keeps its last value after the handshake.
- Latency, with the acceptance edge ending cycle 0:
  - Normal operations: RESULT_VALID first high in cycle WIDTH+3 (35 for WIDTH=32).
  - Special cases: RESULT_VALID first high in cycle 3.
- Back-to-back throughput: one operation per WIDTH+4 cycles minimum.
- KILL:
  - In any state other than IDLE, the next state is IDLE and RESULT_VALID=0; RESULT is unchanged.
  - KILL in IDLE has no effect and also blocks acceptance that cycle.
  - KILL together with RESULT_READY in DONE goes to IDLE; the two are equivalent.
- BUSY equals !READY at all times.

Test Plan:
- Multiply results and latency, WIDTH=32:
  - MUL 7 × 0xFFFFFFFD -> RESULT=0xFFFFFFEB, RESULT_VALID first high in cycle 35.
  - MULH with the same operands -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF; MUL with the same operands -> 0x00000001.
- Divide rounding toward zero:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases, each with RESULT_VALID in cycle 3:
  - DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Backpressure: hold RESULT_READY low for 10 cycles in DONE.
  - RESULT stays constant, READY=0, and START pulses are ignored.
  - On RESULT_READY=1, READY=1 the next cycle, and a new DIVU 9 / 3 -> 3.
- KILL in cycle 12 of CALC:
  - No RESULT_VALID, READY=1 the next cycle.
  - A following MUL 6 × 7 -> 42 in cycle 35.
  - Repeat with RESET instead of KILL: all outputs read reset values the next cycle.
